// File: rtl/clock_tick_gen.sv
// clock_tick_gen
// Multi-channel, runtime-programmable clock-enable generator for the stopwatch
// timing chain. Each channel divides clk by its own divisor and produces a
// one-cycle tick (to be used as an enable, never as a clock) and a near-50%
// square wave. Divisor writes land in a shadow register and are committed only
// at the channel's next wrap, or immediately by a global clear, so a period is
// never cut short or stretched mid-flight.

module clock_tick_gen #(
    parameter  int          N_CH        = 4,
    parameter  int          CNT_W       = 27,
    parameter  int unsigned DIV_DEFAULT = 10_000_000,
    localparam int          CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_run,
    input  logic             i_clear,
    input  logic             i_wr_en,
    input  logic [CH_W-1:0]  i_wr_ch,
    input  logic [CNT_W-1:0] i_wr_div,
    output logic [N_CH-1:0]  o_tick,
    output logic [N_CH-1:0]  o_sq,
    output logic [N_CH-1:0]  o_pending
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CH_W:0]    NCH_L   = (CH_W + 1)'(N_CH);

    // Length of the high phase for a given divisor: ceil(div/2).
    // Computed one bit wider so the +1 cannot overflow at the top of the range.
    function automatic logic [CNT_W-1:0] hi_len(input logic [CNT_W-1:0] d);
        logic [CNT_W:0] s;
        s = {1'b0, d} + {{CNT_W{1'b0}}, 1'b1};
        return s[CNT_W:1];
    endfunction

    // A write addressed to a channel that does not exist is dropped.
    logic wr_ok;
    assign wr_ok = i_wr_en && ({1'b0, i_wr_ch} < NCH_L);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] div_act;
        logic [CNT_W-1:0] div_shd;
        logic             pend;
        logic             armed;
        logic             tick;
        logic             sq;

        logic             wr_hit;
        logic             enabled;
        logic             wrap;
        logic             commit;
        logic             armed_nxt;
        logic [CNT_W-1:0] cnt_nxt;
        logic [CNT_W-1:0] div_nxt;

        assign wr_hit    = wr_ok && (i_wr_ch == CH_W'(g));
        assign enabled   = (div_act != '0);
        assign wrap      = i_run && enabled && (cnt == div_act - ONE);
        // A write landing on the wrap edge is committed by that same wrap.
        assign commit    = wrap && (pend || wr_hit);
        assign div_nxt   = commit ? (wr_hit ? i_wr_div : div_shd) : div_act;
        assign cnt_nxt   = wrap ? '0 : cnt + ONE;
        // The square wave stays low until the first wrap after reset/clear,
        // so the first visible high phase is always a full-length one.
        assign armed_nxt = armed | wrap;

        // Per-channel counter, divisor shadowing and registered outputs.
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt     <= '0;
                div_act <= DIV_RST;
                div_shd <= DIV_RST;
                pend    <= 1'b0;
                armed   <= 1'b0;
                tick    <= 1'b0;
                sq      <= 1'b0;
            end else if (i_clear) begin
                // Clear restarts every channel and commits any waiting divisor;
                // a write on this very edge is committed directly.
                cnt   <= '0;
                pend  <= 1'b0;
                armed <= 1'b0;
                tick  <= 1'b0;
                sq    <= 1'b0;
                if (wr_hit) begin
                    div_act <= i_wr_div;
                    div_shd <= i_wr_div;
                end else begin
                    div_act <= div_shd;
                end
            end else begin
                if (wr_hit) begin
                    div_shd <= i_wr_div;
                    pend    <= 1'b1;
                end
                if (!enabled) begin
                    // Divisor 0 parks the channel; only a clear can revive it.
                    cnt  <= '0;
                    tick <= 1'b0;
                    sq   <= 1'b0;
                end else if (!i_run) begin
                    // Paused: count and square wave hold, no enables issued.
                    tick <= 1'b0;
                end else begin
                    cnt   <= cnt_nxt;
                    tick  <= wrap;
                    armed <= armed_nxt;
                    sq    <= armed_nxt && (cnt_nxt < hi_len(div_nxt));
                    if (commit) begin
                        div_act <= div_nxt;
                        pend    <= 1'b0;
                    end
                end
            end
        end

        assign o_tick[g]    = tick;
        assign o_sq[g]      = sq;
        assign o_pending[g] = pend;
    end

endmodule
